// File: rtl/frame_demapper_if.sv
`timescale 1ns/1ps
// Byte-stream interface of the frame demapper: received line bytes in,
// extracted payload, position, lock and CRC verdict outputs out.
interface frame_demapper_if;
    logic [7:0]  i_frame_data;
    logic        i_frame_data_valid;
    logic [7:0]  o_pyld_data;
    logic        o_pyld_data_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_frame_start;
    logic        o_locked;
    logic        o_crc_ok;
    logic        o_crc_err;
    logic [15:0] o_crc_err_cnt;

    modport master (
        output i_frame_data, i_frame_data_valid,
        input  o_pyld_data, o_pyld_data_valid, o_row_cnt, o_col_cnt,
               o_frame_start, o_locked, o_crc_ok, o_crc_err, o_crc_err_cnt
    );

    modport slave (
        input  i_frame_data, i_frame_data_valid,
        output o_pyld_data, o_pyld_data_valid, o_row_cnt, o_col_cnt,
               o_frame_start, o_locked, o_crc_ok, o_crc_err, o_crc_err_cnt
    );
endinterface

// File: rtl/frame_demapper.sv
`timescale 1ns/1ps
// Frame demapper: hunts for the 16-byte FAS, confirms it over one frame, then
// extracts payload bytes and checks the per-frame CRC-8 while locked.
module frame_demapper (
    input  logic            i_clk,
    input  logic            i_rst,
    frame_demapper_if.slave bus
);
    localparam logic [10:0]  LAST_COL    = 11'd1040;
    localparam logic [7:0]   FAS_A       = 8'hF6;
    localparam logic [7:0]   FAS_B       = 8'h28;
    localparam logic [127:0] FAS_PATTERN = {{8{FAS_A}}, {8{FAS_B}}};

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t       state_q, state_d;
    logic [119:0] shiftReg_q, shiftReg_d;
    logic [1:0]   row_q, row_d;
    logic [10:0]  col_q, col_d;
    logic [7:0]   crc_q, crc_d;
    logic         fasBad_q, fasBad_d;
    logic [1:0]   badCnt_q, badCnt_d;
    logic [7:0]   pyldData_q, pyldData_d;
    logic         pyldValid_q, pyldValid_d;
    logic [1:0]   outRow_q, outRow_d;
    logic [10:0]  outCol_q, outCol_d;
    logic         frameStart_q, frameStart_d;
    logic         crcOk_q, crcOk_d;
    logic         crcErr_q, crcErr_d;
    logic [15:0]  errCnt_q, errCnt_d;

    logic [127:0] shiftNext;
    logic         isFasPos, isCrcPos, isPayload, isFrameStart, isEndOfFas;
    logic         fasMiss, frameBad;
    logic [7:0]   fasExpect;

    function automatic logic [7:0] crc8Byte(input logic [7:0] crcIn, input logic [7:0] dataIn);
        logic [7:0] c;
        c = crcIn ^ dataIn;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign shiftNext    = {shiftReg_q, bus.i_frame_data};
    assign isFasPos     = (row_q == 2'd0) && (col_q < 11'd16);
    assign isCrcPos     = (row_q == 2'd3) && (col_q == LAST_COL);
    assign isPayload    = !isFasPos && !isCrcPos;
    assign isFrameStart = (row_q == 2'd0) && (col_q == 11'd16);
    assign isEndOfFas   = (row_q == 2'd0) && (col_q == 11'd15);
    assign fasExpect    = col_q[3] ? FAS_B : FAS_A;
    assign fasMiss      = (bus.i_frame_data != fasExpect);
    assign frameBad     = fasBad_q | fasMiss;

    // Sequencing, alignment FSM, CRC and output staging; nothing moves on invalid cycles.
    always_comb begin
        state_d      = state_q;
        shiftReg_d   = shiftReg_q;
        row_d        = row_q;
        col_d        = col_q;
        crc_d        = crc_q;
        fasBad_d     = fasBad_q;
        badCnt_d     = badCnt_q;
        pyldData_d   = pyldData_q;
        pyldValid_d  = 1'b0;
        outRow_d     = outRow_q;
        outCol_d     = outCol_q;
        frameStart_d = 1'b0;
        crcOk_d      = 1'b0;
        crcErr_d     = 1'b0;
        errCnt_d     = errCnt_q;

        if (bus.i_frame_data_valid) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 2'd1;
            end else begin
                col_d = col_q + 11'd1;
            end

            if (isFrameStart) begin
                crc_d = crc8Byte(8'h00, bus.i_frame_data);
            end else if (isPayload) begin
                crc_d = crc8Byte(crc_q, bus.i_frame_data);
            end

            if (isFasPos) begin
                fasBad_d = (col_q == 11'd0) ? fasMiss : frameBad;
            end

            case (state_q)
                HUNT: begin
                    shiftReg_d = shiftNext[119:0];
                    if (shiftNext == FAS_PATTERN) begin
                        state_d = CHECK;
                        row_d   = 2'd0;
                        col_d   = 11'd16;
                    end
                end
                CHECK: begin
                    if (isEndOfFas) begin
                        if (frameBad) begin
                            state_d    = HUNT;
                            shiftReg_d = '0;
                            badCnt_d   = '0;
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (isPayload) begin
                        pyldValid_d  = 1'b1;
                        pyldData_d   = bus.i_frame_data;
                        outRow_d     = row_q;
                        outCol_d     = col_q;
                        frameStart_d = isFrameStart;
                    end
                    if (isCrcPos) begin
                        if (bus.i_frame_data == crc_q) begin
                            crcOk_d = 1'b1;
                        end else begin
                            crcErr_d = 1'b1;
                            if (errCnt_q != 16'hFFFF) begin
                                errCnt_d = errCnt_q + 16'd1;
                            end
                        end
                    end
                    // Third consecutive bad FAS drops lock; a good one forgives earlier misses.
                    if (isEndOfFas) begin
                        if (!frameBad) begin
                            badCnt_d = '0;
                        end else if (badCnt_q == 2'd2) begin
                            state_d    = HUNT;
                            shiftReg_d = '0;
                            badCnt_d   = '0;
                        end else begin
                            badCnt_d = badCnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= HUNT;
            shiftReg_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            crc_q        <= '0;
            fasBad_q     <= 1'b0;
            badCnt_q     <= '0;
            pyldData_q   <= '0;
            pyldValid_q  <= 1'b0;
            outRow_q     <= '0;
            outCol_q     <= '0;
            frameStart_q <= 1'b0;
            crcOk_q      <= 1'b0;
            crcErr_q     <= 1'b0;
            errCnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            shiftReg_q   <= shiftReg_d;
            row_q        <= row_d;
            col_q        <= col_d;
            crc_q        <= crc_d;
            fasBad_q     <= fasBad_d;
            badCnt_q     <= badCnt_d;
            pyldData_q   <= pyldData_d;
            pyldValid_q  <= pyldValid_d;
            outRow_q     <= outRow_d;
            outCol_q     <= outCol_d;
            frameStart_q <= frameStart_d;
            crcOk_q      <= crcOk_d;
            crcErr_q     <= crcErr_d;
            errCnt_q     <= errCnt_d;
        end
    end

    assign bus.o_pyld_data       = pyldData_q;
    assign bus.o_pyld_data_valid = pyldValid_q;
    assign bus.o_row_cnt         = outRow_q;
    assign bus.o_col_cnt         = outCol_q;
    assign bus.o_frame_start     = frameStart_q;
    assign bus.o_locked          = (state_q == LOCKED);
    assign bus.o_crc_ok          = crcOk_q;
    assign bus.o_crc_err         = crcErr_q;
    assign bus.o_crc_err_cnt     = errCnt_q;
endmodule

// File: tb/tb_frame_demapper.sv
`timescale 1ns/1ps
// Self-checking bench for frame_demapper: random frames streamed through the DUT
// and compared cycle by cycle against a byte-stream reference model.
module tb_frame_demapper;
    localparam int COLS        = 1041;
    localparam int FRAME_LEN   = 4164;
    localparam int PAYLOAD_LEN = 4147;

    logic clk = 1'b0;
    logic rst = 1'b1;

    frame_demapper_if bus();

    frame_demapper dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] crcTable [256];
    logic [7:0] stream [$];

    // Reference model state, indexed by linear position within the frame.
    int         mState = 0;
    logic [7:0] hist [$];
    int         mPos = 0;
    bit         mFasBad = 1'b0;
    int         mBadFrames = 0;
    logic [7:0] mCrc = 8'h00;
    int         mErrCnt = 0;
    bit         ePv = 1'b0, eFs = 1'b0, eLocked = 1'b0, eOk = 1'b0, eErr = 1'b0;
    logic [7:0] eData = 8'h00;
    logic [1:0] eRow = 2'd0;
    logic [10:0] eCol = 11'd0;

    int          nMismatch, nPayload, nOk, nErr, nGapActive;
    int          lockRiseIdx, lockFallIdx, firstBadIdx;
    logic [41:0] firstObs, firstExp;
    bit          prevLocked;

    function automatic logic [7:0] fasByte(input int p);
        return (p < 8) ? 8'hF6 : 8'h28;
    endfunction

    function automatic bit histIsFas();
        if (hist.size() != 16) return 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (hist[i] != fasByte(i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [41:0] observedVec();
        return {bus.o_pyld_data_valid, bus.o_pyld_data_valid ? bus.o_pyld_data : 8'h00,
                bus.o_row_cnt, bus.o_col_cnt, bus.o_frame_start, bus.o_locked,
                bus.o_crc_ok, bus.o_crc_err, bus.o_crc_err_cnt};
    endfunction

    function automatic logic [41:0] expectedVec();
        return {ePv, ePv ? eData : 8'h00, eRow, eCol, eFs, eLocked, eOk, eErr, 16'(mErrCnt)};
    endfunction

    task automatic buildCrcTable();
        logic [7:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 8'(i);
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
            end
            crcTable[i] = c;
        end
    endtask

    task automatic appendFrame(input bit badFas, input bit flipOne);
        logic [7:0] f [FRAME_LEN];
        logic [7:0] crc;
        int k;
        crc = 8'h00;
        for (int p = 0; p < FRAME_LEN; p++) begin
            if (p < 16) begin
                f[p] = fasByte(p);
            end else if (p == FRAME_LEN - 1) begin
                f[p] = crc;
            end else begin
                f[p] = 8'($urandom);
                crc  = crcTable[crc ^ f[p]];
            end
        end
        if (badFas) f[3] = 8'h00;
        if (flipOne) begin
            k = int'($urandom_range(FRAME_LEN - 2, 16));
            f[k] = f[k] ^ 8'h01;
        end
        for (int p = 0; p < FRAME_LEN; p++) stream.push_back(f[p]);
    endtask

    task automatic appendGarbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hF6 || b == 8'h28) b = b ^ 8'h01;
            stream.push_back(b);
        end
    endtask

    task automatic modelStep(input bit v, input logic [7:0] d, input bit r);
        int  nextPos;
        bit  miss;
        ePv = 1'b0; eFs = 1'b0; eOk = 1'b0; eErr = 1'b0;
        if (r) begin
            mState = 0; hist.delete(); mPos = 0; mFasBad = 1'b0; mBadFrames = 0;
            mCrc = 8'h00; mErrCnt = 0; eData = 8'h00; eRow = 2'd0; eCol = 11'd0;
        end else if (v) begin
            miss = (mPos < 16) && (d != fasByte(mPos));
            if (mState == 2) begin
                if (mPos >= 16 && mPos < FRAME_LEN - 1) begin
                    ePv = 1'b1; eData = d; eFs = (mPos == 16);
                    eRow = 2'(mPos / COLS); eCol = 11'(mPos % COLS);
                end
                if (mPos == FRAME_LEN - 1) begin
                    if (d == mCrc) eOk = 1'b1;
                    else begin
                        eErr = 1'b1;
                        if (mErrCnt < 65535) mErrCnt++;
                    end
                end
            end
            if (mPos == 16) mCrc = crcTable[d];
            else if (mPos > 16 && mPos < FRAME_LEN - 1) mCrc = crcTable[mCrc ^ d];
            if (mPos < 16) mFasBad = (mPos == 0) ? miss : (mFasBad | miss);
            nextPos = (mPos + 1) % FRAME_LEN;
            if (mState == 0) begin
                hist.push_back(d);
                if (hist.size() > 16) hist.delete(0);
                if (histIsFas()) begin
                    mState = 1;
                    nextPos = 16;
                end
            end else if (mPos == 15) begin
                if (mState == 1) begin
                    mState = mFasBad ? 0 : 2;
                end else if (!mFasBad) begin
                    mBadFrames = 0;
                end else begin
                    mBadFrames++;
                    if (mBadFrames == 3) begin
                        mState = 0;
                        mBadFrames = 0;
                    end
                end
                if (mState == 0) hist.delete();
            end
            mPos = nextPos;
        end
        eLocked = (mState == 2);
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
        bus.i_frame_data_valid = v;
        bus.i_frame_data       = d;
        rst                    = r;
        @(posedge clk);
        modelStep(v, d, r);
        #1;
    endtask

    task automatic scoreCycle(input bit wasGap, input int idx);
        if (observedVec() !== expectedVec()) begin
            if (nMismatch == 0) begin
                firstBadIdx = idx; firstObs = observedVec(); firstExp = expectedVec();
            end
            nMismatch++;
        end
        if (wasGap && (bus.o_pyld_data_valid || bus.o_frame_start || bus.o_crc_ok || bus.o_crc_err))
            nGapActive++;
        if (bus.o_pyld_data_valid === 1'b1) nPayload++;
        if (bus.o_crc_ok === 1'b1) nOk++;
        if (bus.o_crc_err === 1'b1) nErr++;
        if (!prevLocked && bus.o_locked === 1'b1 && lockRiseIdx < 0) lockRiseIdx = idx;
        if (prevLocked && bus.o_locked === 1'b0 && lockFallIdx < 0) lockFallIdx = idx;
        prevLocked = (bus.o_locked === 1'b1);
    endtask

    task automatic feedStream(input int gapPct);
        int idx;
        int gaps;
        logic [7:0] b;
        idx = 0;
        nMismatch = 0; nPayload = 0; nOk = 0; nErr = 0; nGapActive = 0;
        lockRiseIdx = -1; lockFallIdx = -1; firstBadIdx = -1;
        firstObs = '0; firstExp = '0;
        prevLocked = (bus.o_locked === 1'b1);
        while (stream.size() > 0) begin
            b = stream.pop_front();
            gaps = 0;
            while (gapPct > 0 && gaps < 8 && int'($urandom_range(99)) < gapPct) begin
                applyStimulus(1'b0, 8'($urandom), 1'b0);
                scoreCycle(1'b1, idx);
                gaps++;
            end
            applyStimulus(1'b1, b, 1'b0);
            scoreCycle(1'b0, idx);
            idx++;
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'hF6, 1'b1);
        checks++;
        if (observedVec() !== 42'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", observedVec(), 42'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checks++;
        if (observedVec() !== 42'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_outputs got %h want %h", observedVec(), 42'd0);
        end
        checks++;
        if (bus.o_locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_locked got %b want 0", bus.o_locked);
        end
    endtask

    task automatic test_clean_lock();
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        appendFrame(1'b0, 1'b0);
        appendFrame(1'b0, 1'b0);
        feedStream(0);
        checks++;
        if (nMismatch !== 0) begin
            errors++;
            $display("[TB] FAIL clean_model got %0d bad cycles (first byte %0d obs %h exp %h) want 0", nMismatch, firstBadIdx, firstObs, firstExp);
        end
        checks++;
        if (lockRiseIdx !== FRAME_LEN + 15) begin
            errors++;
            $display("[TB] FAIL clean_lock_point got %0d want %0d", lockRiseIdx, FRAME_LEN + 15);
        end
        checks++;
        if (nPayload !== PAYLOAD_LEN) begin
            errors++;
            $display("[TB] FAIL clean_payload_count got %0d want %0d", nPayload, PAYLOAD_LEN);
        end
        checks++;
        if (nOk !== 1) begin
            errors++;
            $display("[TB] FAIL clean_crc_ok got %0d want 1", nOk);
        end
        checks++;
        if (nErr !== 0) begin
            errors++;
            $display("[TB] FAIL clean_crc_err got %0d want 0", nErr);
        end
        checks++;
        if (bus.o_crc_err_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clean_err_cnt got %0d want 0", bus.o_crc_err_cnt);
        end
    endtask

    task automatic test_crc_error();
        appendFrame(1'b0, 1'b1);
        feedStream(0);
        checks++;
        if (nMismatch !== 0) begin
            errors++;
            $display("[TB] FAIL crcerr_model got %0d bad cycles (first byte %0d obs %h exp %h) want 0", nMismatch, firstBadIdx, firstObs, firstExp);
        end
        checks++;
        if (nErr !== 1 || nOk !== 0) begin
            errors++;
            $display("[TB] FAIL crcerr_verdict got err %0d ok %0d want err 1 ok 0", nErr, nOk);
        end
        checks++;
        if (bus.o_crc_err_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL crcerr_err_cnt got %0d want 1", bus.o_crc_err_cnt);
        end
        checks++;
        if (bus.o_locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL crcerr_lock_kept got %b want 1", bus.o_locked);
        end
        checks++;
        if (nPayload !== PAYLOAD_LEN) begin
            errors++;
            $display("[TB] FAIL crcerr_payload_count got %0d want %0d", nPayload, PAYLOAD_LEN);
        end
    endtask

    task automatic test_fas_loss();
        for (int i = 0; i < 3; i++) appendFrame(1'b1, 1'b0);
        feedStream(0);
        checks++;
        if (nMismatch !== 0) begin
            errors++;
            $display("[TB] FAIL fasloss_model got %0d bad cycles (first byte %0d obs %h exp %h) want 0", nMismatch, firstBadIdx, firstObs, firstExp);
        end
        checks++;
        if (lockFallIdx !== 2 * FRAME_LEN + 15) begin
            errors++;
            $display("[TB] FAIL fasloss_drop_point got %0d want %0d", lockFallIdx, 2 * FRAME_LEN + 15);
        end
        checks++;
        if (nPayload !== 2 * PAYLOAD_LEN) begin
            errors++;
            $display("[TB] FAIL fasloss_payload_count got %0d want %0d", nPayload, 2 * PAYLOAD_LEN);
        end
        appendFrame(1'b0, 1'b0);
        appendFrame(1'b0, 1'b0);
        feedStream(0);
        checks++;
        if (lockRiseIdx !== FRAME_LEN + 15) begin
            errors++;
            $display("[TB] FAIL fasloss_relock_point got %0d want %0d", lockRiseIdx, FRAME_LEN + 15);
        end
        checks++;
        if (bus.o_locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fasloss_relocked got %b want 1", bus.o_locked);
        end
        checks++;
        if (bus.o_crc_err_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL fasloss_err_cnt got %0d want 1", bus.o_crc_err_cnt);
        end
    endtask

    task automatic test_gaps();
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) appendFrame(1'b0, 1'b0);
        feedStream(30);
        checks++;
        if (nMismatch !== 0) begin
            errors++;
            $display("[TB] FAIL gaps_model got %0d bad cycles (first byte %0d obs %h exp %h) want 0", nMismatch, firstBadIdx, firstObs, firstExp);
        end
        checks++;
        if (nGapActive !== 0) begin
            errors++;
            $display("[TB] FAIL gaps_idle_outputs got %0d active gap cycles want 0", nGapActive);
        end
        checks++;
        if (nPayload !== 2 * PAYLOAD_LEN) begin
            errors++;
            $display("[TB] FAIL gaps_payload_count got %0d want %0d", nPayload, 2 * PAYLOAD_LEN);
        end
        checks++;
        if (nOk !== 2) begin
            errors++;
            $display("[TB] FAIL gaps_crc_ok got %0d want 2", nOk);
        end
        checks++;
        if (lockRiseIdx !== FRAME_LEN + 15) begin
            errors++;
            $display("[TB] FAIL gaps_lock_point got %0d want %0d", lockRiseIdx, FRAME_LEN + 15);
        end
    endtask

    task automatic test_false_fas();
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        appendGarbage(500);
        for (int p = 0; p < 16; p++) stream.push_back(fasByte(p));
        appendGarbage(4200);
        appendFrame(1'b0, 1'b0);
        appendFrame(1'b0, 1'b0);
        feedStream(0);
        checks++;
        if (nMismatch !== 0) begin
            errors++;
            $display("[TB] FAIL falsefas_model got %0d bad cycles (first byte %0d obs %h exp %h) want 0", nMismatch, firstBadIdx, firstObs, firstExp);
        end
        checks++;
        if (lockRiseIdx !== 500 + 16 + 4200 + FRAME_LEN + 15) begin
            errors++;
            $display("[TB] FAIL falsefas_lock_point got %0d want %0d", lockRiseIdx, 500 + 16 + 4200 + FRAME_LEN + 15);
        end
        checks++;
        if (nOk !== 1) begin
            errors++;
            $display("[TB] FAIL falsefas_crc_ok got %0d want 1", nOk);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] hold [$];
        appendFrame(1'b0, 1'b0);
        for (int i = 0; i < FRAME_LEN - 2582; i++) hold.push_front(stream.pop_back());
        feedStream(0);
        checks++;
        if (bus.o_locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_locked_before got %b want 1", bus.o_locked);
        end
        applyStimulus(1'b1, hold.pop_front(), 1'b1);
        checks++;
        if (observedVec() !== 42'd0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs got %h want %h", observedVec(), 42'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        while (hold.size() > 0) stream.push_back(hold.pop_front());
        appendFrame(1'b0, 1'b0);
        appendFrame(1'b0, 1'b0);
        feedStream(0);
        checks++;
        if (nMismatch !== 0) begin
            errors++;
            $display("[TB] FAIL midrst_model got %0d bad cycles (first byte %0d obs %h exp %h) want 0", nMismatch, firstBadIdx, firstObs, firstExp);
        end
        checks++;
        if (lockRiseIdx !== 1581 + FRAME_LEN + 15) begin
            errors++;
            $display("[TB] FAIL midrst_relock_point got %0d want %0d", lockRiseIdx, 1581 + FRAME_LEN + 15);
        end
        checks++;
        if (nOk !== 1 || nErr !== 0) begin
            errors++;
            $display("[TB] FAIL midrst_verdicts got ok %0d err %0d want ok 1 err 0", nOk, nErr);
        end
    endtask

    initial begin
        buildCrcTable();
        test_reset();
        test_clean_lock();
        test_crc_error();
        test_fas_loss();
        test_gaps();
        test_false_fas();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_demapper.md
FRAME_DEMAPPER -- requirements
Module: frame_demapper

Interface
REQ-001 Clock i_clk; reset i_rst, synchronous, active-high.
REQ-002 i_clk  in  1  rising-edge clock for all state.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_frame_data  in  8  received line byte.
REQ-005 i_frame_data_valid  in  1  byte qualifier; all counters and the CRC advance only on valid cycles.
REQ-006 o_pyld_data  out  8  extracted payload byte.
REQ-007 o_pyld_data_valid  out  1  high for one cycle per payload byte.
REQ-008 o_row_cnt  out  2  row of the current output byte.
REQ-009 o_col_cnt  out  11  column of the current output byte.
REQ-010 o_frame_start  out  1  pulse with the first payload byte (row 0, col 16) of each locked frame.
REQ-011 o_locked  out  1  high while in LOCKED.
REQ-012 o_crc_ok / o_crc_err  out  1 each  one-cycle verdict pulses at the CRC byte.
REQ-013 o_crc_err_cnt  out  16  saturating count of CRC failures.

Function
REQ-014 Frame geometry: 4 rows (0..3) x 1041 columns (0..1040), 4164 bytes per frame, transmitted row-major.
REQ-015 FAS: row 0, cols 0..15; cols 0..7 = 0xF6, cols 8..15 = 0x28.
REQ-016 CRC byte: row 3, col 1040; every other non-FAS position is payload.
REQ-017 CRC: CRC-8, polynomial 0x07, init 0x00, MSB first, no final XOR, over payload bytes only, in transmit order; cleared at each row 0 col 16.
REQ-018 States: HUNT, CHECK, LOCKED; reset enters HUNT.
REQ-019 HUNT: 16-byte shift register of the last valid bytes; full FAS match -> CHECK, with counters set so the next valid byte is row 0 col 16.
REQ-020 Position counters: col increments on each valid byte; col 1040 wraps to 0 and increments row; row 3 col 1040 wraps to row 0 col 0.
REQ-021 CHECK: at row 0 cols 0..15 each byte is compared to FAS; all 16 match -> LOCKED at col 16; any mismatch -> HUNT at the end of col 15.
REQ-022 LOCKED: same per-frame FAS check; a frame with any FAS mismatch is bad; 3 consecutive bad frames -> HUNT; a good frame clears the bad count.
REQ-023 Entering HUNT clears the shift register; search restarts with the next valid byte.
REQ-024 Payload output only in LOCKED: registered, 1-cycle latency from the input byte; FAS and CRC bytes are never output.
REQ-025 o_row_cnt/o_col_cnt are registered with the data and hold their value on invalid cycles.
REQ-026 CRC verdict in LOCKED only: at the CRC byte, received == computed -> o_crc_ok, else o_crc_err; 1-cycle latency; the first partial frame after lock is checked normally.
REQ-027 o_crc_err_cnt increments on o_crc_err and saturates at 0xFFFF; cleared only by reset.
REQ-028 An invalid input cycle holds all state and drives both valid/pulse outputs low.
REQ-029 o_locked drops in the same cycle the FSM enters HUNT; payload output stops from the next byte.

Reset
REQ-030 On i_rst: state HUNT, shift register 0, counters 0, CRC 0, bad count 0, o_crc_err_cnt 0.
REQ-031 All outputs 0 during and after reset until set by function.
REQ-032 i_rst mid-frame aborts the frame immediately with no verdict pulse; reacquisition requires a new FAS plus one confirming frame.

Verification
REQ-033 Two clean frames with random payload and correct CRC, valid always high -> o_locked rises at second-frame row 0 col 16; 4147 payload bytes per frame; o_crc_ok pulses; o_crc_err_cnt = 0.
REQ-034 Locked, then one payload byte XORed with 0x01 -> o_crc_err pulse at the CRC byte; o_crc_err_cnt = 1; lock retained.
REQ-035 Locked, then 3 frames with FAS byte col 3 = 0x00 -> o_locked falls at row 0 col 15 of the third frame; after 2 clean frames o_locked = 1 again.
REQ-036 Random valid gaps (~30% low) over 3 frames -> output identical to the gap-free run; no outputs on invalid cycles.
REQ-037 Leading 500 garbage bytes plus an isolated false FAS one frame before the real frame -> CHECK fails back to HUNT, then locks on the real FAS.
REQ-038 i_rst asserted at row 2 col 500 -> all outputs 0 next cycle; no verdict pulse; relock after 2 frames.
